// File: rtl/qspi_psram_pkg.sv
// qspi_psram_pkg: opcodes, FSM state encoding and page size shared by the QSPI PSRAM slave.
package qspi_psram_pkg;
  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_QPI_EX = 8'hF5;
  localparam logic [7:0] CMD_RST_EN = 8'h66;
  localparam logic [7:0] CMD_RST    = 8'h99;
  localparam int PAGE_BYTES = 1024;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, RDATA, WDATA, DONE} state_e;
endpackage

// File: rtl/qspi_psram_mem.sv
// qspi_psram_mem: single-port byte array, synchronous write, registered read of the current address.
module qspi_psram_mem #(
  parameter int ADR_W = 16
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ADR_W-1:0] addr_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o
);
  logic [7:0] mem_q [2**ADR_W];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/qspi_psram_slave.sv
// qspi_psram_slave: clk-domain QSPI/QPI PSRAM slave with quad read/write, QPI enter/exit and reset.
// Define PSRAM_PAGE_WRAP_EN to wrap bursts inside a 1024-byte page instead of at the array end.
module qspi_psram_slave
  import qspi_psram_pkg::*;
#(
  parameter int ADR_W       = 16,
  parameter int WAIT_CYCLES = 6,
  parameter int INIT_QPI    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic       sio_oe,
  output logic       qpi_mode
);
  state_e           state_q;
  logic             sck_q, rd_q, ph_q, qpi_q, rst_en_q, sio_oe_q;
  logic [7:0]       cnt_q, op, rdata;
  logic [19:0]      sh_q;
  logic [3:0]       hi_q, sio_o_q;
  logic [ADR_W-1:0] addr_q, addr_inc;
  logic             rise, fall, we, cmd_last;
  assign rise = sck & ~sck_q;
  assign fall = ~sck & sck_q;
  assign op = qpi_q ? {sh_q[3:0], sio_i} : {sh_q[6:0], sio_i[0]};
  assign cmd_last = cnt_q == (qpi_q ? 8'd1 : 8'd7);
  assign we = rise & ~ce_n & (state_q == WDATA) & ph_q;
`ifdef PSRAM_PAGE_WRAP_EN
  localparam logic [ADR_W-1:0] PMASK = ADR_W'(PAGE_BYTES - 1);
  assign addr_inc = (addr_q & ~PMASK) | ((addr_q + 1'b1) & PMASK);
`else
  assign addr_inc = addr_q + 1'b1;
`endif
  assign sio_o = sio_o_q;
  assign sio_oe = sio_oe_q;
  assign qpi_mode = qpi_q;
  qspi_psram_mem #(.ADR_W(ADR_W)) u_mem (
    .clk(clk), .we_i(we), .addr_i(addr_q), .wdata_i({hi_q, sio_i}), .rdata_o(rdata)
  );
  always_ff @(posedge clk) begin
    sck_q <= sck;
    if (!rst_n) begin
      state_q <= IDLE;
      sio_o_q <= '0;
      sio_oe_q <= 1'b0;
      qpi_q <= 1'(INIT_QPI);
      rst_en_q <= 1'b0;
      cnt_q <= '0;
      ph_q <= 1'b0;
    end else if (ce_n) begin
      state_q <= IDLE;
      sio_oe_q <= 1'b0;
      cnt_q <= '0;
      ph_q <= 1'b0;
    end else if (rise) begin
      case (state_q)
        IDLE, CMD: begin
          sh_q <= qpi_q ? {sh_q[15:0], sio_i} : {sh_q[18:0], sio_i[0]};
          cnt_q <= cnt_q + 1'b1;
          state_q <= CMD;
          if (cmd_last) begin
            cnt_q <= '0;
            rst_en_q <= op == CMD_RST_EN;
            state_q <= DONE;
            case (op)
              CMD_QREAD:  begin state_q <= ADDR; rd_q <= 1'b1; end
              CMD_QWRITE: begin state_q <= ADDR; rd_q <= 1'b0; end
              CMD_QPI_EN: qpi_q <= 1'b1;
              CMD_QPI_EX: qpi_q <= 1'b0;
              CMD_RST:    if (rst_en_q) qpi_q <= 1'(INIT_QPI);
              default: ;
            endcase
          end
        end
        ADDR: begin
          sh_q <= {sh_q[15:0], sio_i};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == 8'd5) begin
            addr_q <= ADR_W'({sh_q, sio_i});
            cnt_q <= '0;
            ph_q <= 1'b0;
            state_q <= rd_q ? ((WAIT_CYCLES == 0) ? RDATA : WAIT) : WDATA;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == 8'(WAIT_CYCLES - 1)) state_q <= RDATA;
        end
        WDATA: begin
          ph_q <= ~ph_q;
          if (!ph_q) hi_q <= sio_i;
          else addr_q <= addr_inc;
        end
        default: ;
      endcase
    end else if (fall && state_q == RDATA) begin
      // rdata was prefetched from addr_q at least one clk before this fall
      sio_oe_q <= 1'b1;
      sio_o_q <= ph_q ? rdata[3:0] : rdata[7:4];
      ph_q <= ~ph_q;
      if (ph_q) addr_q <= addr_inc;
    end
  end
endmodule

// File: doc/qspi_psram_slave.md
Name: qspi_psram_slave

Overview:
Parametrised, synthesizable QSPI PSRAM slave that replaces the fixed single-mode PSRAM model behind qspi_if in the inner-memory FPGA check path. It works in the clk domain: it detects sck edges, decodes SPI or QPI commands, and serves quad reads and writes from an internal byte array. Configurable depth and wait count; adds QPI enter/exit and reset-enable/reset, which the previous model lacks.

Parameters:
ADR_W, 16, byte-address bits of internal array (MEM_BYTES = 2**ADR_W)
WAIT_CYCLES, 6, sck rising edges between last address nibble and first read nibble for 0xEB
INIT_QPI, 0, 1 = leave reset in QPI mode, 0 = SPI mode

Ports:
clk  input  1  system clock; sck is generated synchronously in this domain
rst_n  input  1  synchronous active-low reset
sck  input  1  serial clock from master, at most clk/2
ce_n  input  1  chip enable, active low
sio_i  input  4  data from master
sio_o  output  4  data to master
sio_oe  output  1  1 while slave drives sio_o
qpi_mode  output  1  current mode, 1 = QPI (debug/status)

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; sio_o=0, sio_oe=0; qpi_mode=INIT_QPI; rst_en flag=0; array contents not cleared.
- Edge detect: sck registered once; rise = sck & ~sck_d, fall = ~sck & sck_d. sio_i is sampled on rise, and sio_o updates on fall. All actions happen one clk after the edge.
- ce_n high at any clk: go to IDLE next cycle; sio_oe=0; any partial byte or command is discarded. ce_n has priority over an edge in the same cycle.
- States: IDLE -> CMD on the first rise with ce_n low. CMD shifts the opcode MSB first: 8 rises on sio_i[0] in SPI mode, or 2 rises of nibbles (high first) in QPI mode.
- Opcode decode after the last cmd rise:
  - 0xEB -> ADDR (read)
  - 0x38 -> ADDR (write)
  - 0x35 -> sets qpi_mode=1, then DONE
  - 0xF5 -> sets qpi_mode=0, then DONE
  - 0x66 -> sets rst_en=1, then DONE
  - 0x99 -> if rst_en: qpi_mode=INIT_QPI; rst_en is cleared; then DONE
  - any other opcode -> DONE (ignored)
  - rst_en is cleared by any opcode other than 0x66.
- ADDR: 24-bit address over 6 quad rises, high nibble first, in both modes. Bits above ADR_W are ignored.
  - Read (0xEB): ADDR -> WAIT, then WAIT_CYCLES rises -> RDATA.
  - Write (0x38): ADDR -> WDATA.
- RDATA: sio_oe=1 from the first fall after entering RDATA. Each fall drives the next nibble, high nibble first. The byte address increments after the low nibble and wraps modulo MEM_BYTES.
- WDATA: the byte is written on the rise that captures its low nibble; the address then increments with the same wrap rule. A lone high nibble at ce_n rise is dropped.
- DONE: ignore all edges until ce_n high.
- Reads and writes are byte-granular and sequential; there is no burst-length limit.

Optional Feature:
PSRAM_PAGE_WRAP_EN:
- Defined: burst addresses wrap within a 1024-byte page (addr[9:0] increments, upper bits held), matching the real device's page mode.
- Undefined: linear wrap at MEM_BYTES only.

Decomposition:
- Package qspi_psram_pkg holds:
  - opcode localparams: CMD_QREAD=8'hEB, CMD_QWRITE=8'h38, CMD_QPI_EN=8'h35, CMD_QPI_EX=8'hF5, CMD_RST_EN=8'h66, CMD_RST=8'h99
  - state encoding IDLE/CMD/ADDR/WAIT/RDATA/WDATA/DONE
  - PAGE_BYTES=1024
- One sub-module qspi_psram_mem: a single-port byte array with ADR_W address bits, synchronous write and registered read (read prefetched on address change before the next fall).

Test Plan:
- SPI 0x38, addr 0x000100, data 0x12 0x34 0x56 0x78 -> bytes 0x100..0x103 = 12,34,56,78; sio_oe stays 0.
- SPI 0xEB, addr 0x000100, 6 wait rises -> sio_o nibbles 1,2,3,4,5,6,7,8 on successive falls; sio_oe=1 only during data.
- SPI 0x35, then QPI 0xEB in 2 rises -> same data; qpi_mode=1. QPI 0xF5 -> qpi_mode=0.
- Write across the end: ADR_W=16, addr 0xFFFF, two bytes AA,BB -> mem[0xFFFF]=AA, mem[0x0000]=BB. With PSRAM_PAGE_WRAP_EN at addr 0x13FF: mem[0x13FF]=AA, mem[0x1000]=BB.
- ce_n raised after a high nibble of write byte 0xC? -> target byte unchanged; the next command decodes cleanly from IDLE.
- Reset sequences:
  - In QPI mode, 0x66 then 0x99 -> qpi_mode=INIT_QPI.
  - 0x66, 0x00, 0x99 -> no reset.
  - rst_n low mid-RDATA -> sio_oe=0 next clk, state IDLE.
